// File: rtl/dm_abstract_ctrl.sv
// dm_abstract_ctrl: abstract-command sequencer for the debug module.
// Validates Command writes and autoexec triggers against the hart state,
// runs the go/going/done handshake with the debug ROM park loop and owns
// abstractcs.busy / abstractcs.cmderr (including W1C clearing).
module dm_abstract_ctrl #(
  parameter int unsigned MaxAarSize    = 3,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmactive_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic        autoexec_i,
  input  logic        busy_access_i,
  input  logic [2:0]  cmderr_clr_i,
  input  logic        halted_i,
  input  logic        going_i,
  input  logic        done_i,
  input  logic        exception_i,
  output logic        go_o,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  output logic [31:0] cmd_o,
  output logic        cmd_start_o
);

  // cmderr_e encoding
  localparam logic [2:0] ErrNone         = 3'd0;
  localparam logic [2:0] ErrBusy         = 3'd1;
  localparam logic [2:0] ErrNotSupported = 3'd2;
  localparam logic [2:0] ErrException    = 3'd3;
  localparam logic [2:0] ErrHaltResume   = 3'd4;
  localparam logic [2:0] ErrOther        = 3'd7;

  localparam logic [7:0] CmdAccessReg = 8'h00;
  localparam logic [2:0] MaxAar       = 3'(MaxAarSize);
  localparam logic [2:0] MinAar       = 3'd2;

  // A zero TimeoutCycles still needs a legal (1-bit) counter; it is simply never compared.
  localparam int unsigned     CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic            TimeoutEn = (TimeoutCycles > 0) ? 1'b1 : 1'b0;
  localparam logic [CntW-1:0] CntLast   = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1)
                                                              : {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne    = {{(CntW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    EXEC = 2'd2
  } state_e;

  // A new error only lands when the (post-W1C) sticky value is None.
  function automatic logic [2:0] merge_err(input logic [2:0] masked,
                                           input logic       new_v,
                                           input logic [2:0] new_code);
    logic [2:0] res;
    if (new_v && (masked == ErrNone)) begin
      res = new_code;
    end else begin
      res = masked;
    end
    return res;
  endfunction

  state_e          state_q, state_d;
  logic [31:0]     cmd_q, cmd_d;
  logic [2:0]      cmderr_q, cmderr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            go_q, go_d;
  logic            busy_q, busy_d;

  logic            new_err_v;
  logic [2:0]      new_err;
  logic [31:0]     trig_cmd;
  logic            timeout_hit;

  // Next-state, command latch, error and timeout-counter logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    new_err_v   = 1'b0;
    new_err     = ErrNone;
    trig_cmd    = cmd_q;
    timeout_hit = TimeoutEn && (cnt_q == CntLast);

    case (state_q)
      IDLE: begin
        if ((cmd_valid_i || autoexec_i) && (cmderr_q == ErrNone)) begin
          // A Command write wins over autoexec and is latched even if rejected.
          if (cmd_valid_i) begin
            trig_cmd = cmd_i;
            cmd_d    = cmd_i;
          end else begin
            trig_cmd = cmd_q;
          end

          if (trig_cmd[31:24] != CmdAccessReg) begin
            new_err_v = 1'b1;
            new_err   = ErrNotSupported;
          end else if (trig_cmd[17] &&
                       ((trig_cmd[22:20] > MaxAar) || (trig_cmd[22:20] < MinAar))) begin
            new_err_v = 1'b1;
            new_err   = ErrNotSupported;
          end else if (!halted_i) begin
            new_err_v = 1'b1;
            new_err   = ErrHaltResume;
          end else if (!trig_cmd[17] && !trig_cmd[18]) begin
            // Neither transfer nor postexec: nothing for the hart to run.
            start_d = 1'b1;
          end else begin
            start_d = 1'b1;
            state_d = GO;
            cnt_d   = {CntW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end

      GO: begin
        if (cmd_valid_i || autoexec_i || busy_access_i) begin
          new_err_v = 1'b1;
          new_err   = ErrBusy;
        end else begin
          new_err_v = 1'b0;
        end

        if (timeout_hit) begin
          state_d   = IDLE;
          new_err_v = 1'b1;
          new_err   = ErrOther;
        end else if (going_i) begin
          state_d = EXEC;
          cnt_d   = cnt_q + CntOne;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      EXEC: begin
        if (cmd_valid_i || autoexec_i || busy_access_i) begin
          new_err_v = 1'b1;
          new_err   = ErrBusy;
        end else begin
          new_err_v = 1'b0;
        end

        if (exception_i) begin
          state_d   = IDLE;
          new_err_v = 1'b1;
          new_err   = ErrException;
        end else if (done_i) begin
          state_d = IDLE;
          if (cmd_q[19] && cmd_q[17]) begin
            cmd_d[15:0] = cmd_q[15:0] + 16'd1;
          end else begin
            cmd_d = cmd_q;
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          new_err_v = 1'b1;
          new_err   = ErrOther;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmderr_d = merge_err(cmderr_q & ~cmderr_clr_i, new_err_v, new_err);
    go_d     = (state_d == GO);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers; dmactive low behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || !dmactive_i) begin
      state_q  <= IDLE;
      cmd_q    <= 32'h0000_0000;
      cmderr_q <= ErrNone;
      cnt_q    <= {CntW{1'b0}};
      start_q  <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmderr_q <= cmderr_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
    end
  end

  assign go_o        = go_q;
  assign busy_o      = busy_q;
  assign cmderr_o    = cmderr_q;
  assign cmd_o       = cmd_q;
  assign cmd_start_o = start_q;

endmodule

// File: tb/tb_dm_abstract_ctrl.sv
// Directed bench for dm_abstract_ctrl: each step drives inputs, queues the
// expected output snapshot, clocks once and compares the popped expectation.
module tb_dm_abstract_ctrl;

  logic        clk;
  logic        rst_i, dmactive_i, cmd_valid_i, autoexec_i, busy_access_i;
  logic [31:0] cmd_i;
  logic [2:0]  cmderr_clr_i;
  logic        halted_i, going_i, done_i, exception_i;
  logic        go_o, busy_o, cmd_start_o;
  logic [2:0]  cmderr_o;
  logic [31:0] cmd_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        busy;
    logic        go;
    logic [2:0]  err;
    logic [31:0] cmd;
    logic        start;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];

  // transfer=1, write=1, aarpostincrement=1, aarsize=3, regno=0x1000
  localparam logic [31:0] C1 = 32'h003B_1000;

  dm_abstract_ctrl #(.MaxAarSize(3), .TimeoutCycles(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .dmactive_i   (dmactive_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_i        (cmd_i),
    .autoexec_i   (autoexec_i),
    .busy_access_i(busy_access_i),
    .cmderr_clr_i (cmderr_clr_i),
    .halted_i     (halted_i),
    .going_i      (going_i),
    .done_i       (done_i),
    .exception_i  (exception_i),
    .go_o         (go_o),
    .busy_o       (busy_o),
    .cmderr_o     (cmderr_o),
    .cmd_o        (cmd_o),
    .cmd_start_o  (cmd_start_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string tag, input logic busy, input logic go,
                     input logic [2:0] err, input logic [31:0] cmd, input logic start);
    snap_t e;
    snap_t o;
    string t;
    e.busy  = busy;
    e.go    = go;
    e.err   = err;
    e.cmd   = cmd;
    e.start = start;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    cmd_valid_i   = 1'b0;
    autoexec_i    = 1'b0;
    busy_access_i = 1'b0;
    cmderr_clr_i  = 3'b000;
    going_i       = 1'b0;
    done_i        = 1'b0;
    exception_i   = 1'b0;
    o.busy  = busy_o;
    o.go    = go_o;
    o.err   = cmderr_o;
    o.cmd   = cmd_o;
    o.start = cmd_start_o;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed busy=%0b go=%0b cmderr=%0d cmd=%h start=%0b, expected busy=%0b go=%0b cmderr=%0d cmd=%h start=%0b",
             t, o.busy, o.go, o.err, o.cmd, o.start, e.busy, e.go, e.err, e.cmd, e.start);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_i = 1'b1; dmactive_i = 1'b1; halted_i = 1'b1;
    cmd_valid_i = 1'b0; autoexec_i = 1'b0; busy_access_i = 1'b0;
    cmd_i = 32'h0; cmderr_clr_i = 3'b000;
    going_i = 1'b0; done_i = 1'b0; exception_i = 1'b0;

    cyc("reset", 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    rst_i = 1'b0;

    // Basic run with postincrement, then autoexec reruns the latched command.
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("t1_accept", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    cyc("t1_go_hold", 1'b1, 1'b1, 3'd0, C1, 1'b0);
    going_i = 1'b1;
    cyc("t1_going", 1'b1, 1'b0, 3'd0, C1, 1'b0);
    done_i = 1'b1;
    cyc("t1_done", 1'b0, 1'b0, 3'd0, 32'h003B_1001, 1'b0);
    autoexec_i = 1'b1;
    cyc("t1_auto_start", 1'b1, 1'b1, 3'd0, 32'h003B_1001, 1'b1);
    going_i = 1'b1;
    cyc("t1_auto_going", 1'b1, 1'b0, 3'd0, 32'h003B_1001, 1'b0);
    done_i = 1'b1;
    cyc("t1_auto_done", 1'b0, 1'b0, 3'd0, 32'h003B_1002, 1'b0);

    // Unsupported cmdtype, sticky error blocks triggers until W1C.
    cmd_valid_i = 1'b1; cmd_i = 32'h0100_0000;
    cyc("t2_quick", 1'b0, 1'b0, 3'd2, 32'h0100_0000, 1'b0);
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("t2_ignored", 1'b0, 1'b0, 3'd2, 32'h0100_0000, 1'b0);
    cmderr_clr_i = 3'b111;
    cyc("t2_clear", 1'b0, 1'b0, 3'd0, 32'h0100_0000, 1'b0);
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("t2_run", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    going_i = 1'b1;
    cyc("t2_going", 1'b1, 1'b0, 3'd0, C1, 1'b0);
    done_i = 1'b1;
    cyc("t2_done", 1'b0, 1'b0, 3'd0, 32'h003B_1001, 1'b0);

    // Hart not halted, then illegal aarsize.
    halted_i = 1'b0; cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("t3_halt", 1'b0, 1'b0, 3'd4, C1, 1'b0);
    halted_i = 1'b1; cmderr_clr_i = 3'b111;
    cyc("t3_clear1", 1'b0, 1'b0, 3'd0, C1, 1'b0);
    cmd_valid_i = 1'b1; cmd_i = 32'h0042_0000;
    cyc("t3_aarsize4", 1'b0, 1'b0, 3'd2, 32'h0042_0000, 1'b0);
    cmderr_clr_i = 3'b111;
    cyc("t3_clear2", 1'b0, 1'b0, 3'd0, 32'h0042_0000, 1'b0);

    // No-op command (no transfer, no postexec): start pulse only.
    cmd_valid_i = 1'b1; cmd_i = 32'h0000_0005;
    cyc("noop_start", 1'b0, 1'b0, 3'd0, 32'h0000_0005, 1'b1);
    cyc("noop_after", 1'b0, 1'b0, 3'd0, 32'h0000_0005, 1'b0);

    // Simultaneous Command write and autoexec: the write wins.
    cmd_valid_i = 1'b1; autoexec_i = 1'b1; cmd_i = 32'h003B_2000;
    cyc("both_start", 1'b1, 1'b1, 3'd0, 32'h003B_2000, 1'b1);
    going_i = 1'b1;
    cyc("both_going", 1'b1, 1'b0, 3'd0, 32'h003B_2000, 1'b0);
    done_i = 1'b1;
    cyc("both_done", 1'b0, 1'b0, 3'd0, 32'h003B_2001, 1'b0);

    // Busy violation in EXEC; run still completes.
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("t4_start", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    going_i = 1'b1;
    cyc("t4_going", 1'b1, 1'b0, 3'd0, C1, 1'b0);
    busy_access_i = 1'b1;
    cyc("t4_busy", 1'b1, 1'b0, 3'd1, C1, 1'b0);
    done_i = 1'b1;
    cyc("t4_done", 1'b0, 1'b0, 3'd1, 32'h003B_1001, 1'b0);
    cmderr_clr_i = 3'b111;
    cyc("t4_clear", 1'b0, 1'b0, 3'd0, 32'h003B_1001, 1'b0);

    // Exception and done together: exception wins, no postincrement.
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("exc_start", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    going_i = 1'b1;
    cyc("exc_going", 1'b1, 1'b0, 3'd0, C1, 1'b0);
    exception_i = 1'b1; done_i = 1'b1;
    cyc("exc_done", 1'b0, 1'b0, 3'd3, C1, 1'b0);
    cmderr_clr_i = 3'b010;
    cyc("w1c_partial", 1'b0, 1'b0, 3'd1, C1, 1'b0);
    cmderr_clr_i = 3'b111;
    cyc("w1c_all", 1'b0, 1'b0, 3'd0, C1, 1'b0);

    // Timeout with going never asserted: 8 busy cycles then abort.
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("to_start", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc("to_go_hold", 1'b1, 1'b1, 3'd0, C1, 1'b0);
    end
    cyc("to_abort", 1'b0, 1'b0, 3'd7, C1, 1'b0);
    cmderr_clr_i = 3'b111;
    cyc("to_clear", 1'b0, 1'b0, 3'd0, C1, 1'b0);

    // regno wrap on postincrement.
    cmd_valid_i = 1'b1; cmd_i = 32'h003B_FFFF;
    cyc("wrap_start", 1'b1, 1'b1, 3'd0, 32'h003B_FFFF, 1'b1);
    going_i = 1'b1;
    cyc("wrap_going", 1'b1, 1'b0, 3'd0, 32'h003B_FFFF, 1'b0);
    done_i = 1'b1;
    cyc("wrap_done", 1'b0, 1'b0, 3'd0, 32'h003B_0000, 1'b0);

    // Reset in EXEC abandons the command outright.
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("rst_start", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    going_i = 1'b1;
    cyc("rst_going", 1'b1, 1'b0, 3'd0, C1, 1'b0);
    rst_i = 1'b1; done_i = 1'b1;
    cyc("rst_mid", 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    rst_i = 1'b0;

    // dmactive low behaves as reset.
    cmd_valid_i = 1'b1; cmd_i = C1;
    cyc("dma_start", 1'b1, 1'b1, 3'd0, C1, 1'b1);
    dmactive_i = 1'b0;
    cyc("dma_off", 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    dmactive_i = 1'b1;
    cyc("dma_idle", 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
